gpio_control_bank: RTL and testbench

- Parametrised, single-clock successor to the per-pad GPIO control block.
- Serves NCH pads from one serial configuration chain of NCH*PAD_CTRL_BITS bits.
- Adds shift enable, bit counting with load-length checking, config readback capture, a load-done pulse, and a synchronised user-power gate.
- Sits between housekeeping's serial GPIO configuration engine and a group of pad cells.

---
 rtl/gpio_control_bank.sv | 178 +++++++++++++++++
 tb/tb_gpio_control_bank.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_control_bank.sv
// Bank of GPIO pad controllers fed by one serial configuration chain.
// Adds shift enable, load-length checking, config readback and a synced user-power gate.

module gpio_pad_lane (
  input  logic [12:0] cfg,
  input  logic        pwr_ok,
  input  logic        mgmt_gpio_out,
  input  logic        mgmt_gpio_oeb,
  output logic        mgmt_gpio_in,
  input  logic        user_gpio_out,
  input  logic        user_gpio_oeb,
  output logic        user_gpio_in,
  output logic        pad_gpio_holdover,
  output logic        pad_gpio_slow_sel,
  output logic        pad_gpio_vtrip_sel,
  output logic        pad_gpio_inenb,
  output logic        pad_gpio_ib_mode_sel,
  output logic        pad_gpio_ana_en,
  output logic        pad_gpio_ana_sel,
  output logic        pad_gpio_ana_pol,
  output logic        pad_gpio_outenb,
  output logic        pad_gpio_out,
  output logic [2:0]  pad_gpio_dm,
  input  logic        pad_gpio_in
);
  typedef struct packed {
    logic [2:0] dm;
    logic       vtrip_sel;
    logic       slow_sel;
    logic       ana_pol;
    logic       ana_sel;
    logic       ana_en;
    logic       ib_mode_sel;
    logic       inp_dis;
    logic       holdover;
    logic       oeb;
    logic       mgmt_ena;
  } pad_cfg_t;

  pad_cfg_t c;
  assign c = pad_cfg_t'(cfg);

  assign pad_gpio_holdover    = c.holdover;
  assign pad_gpio_slow_sel    = c.slow_sel;
  assign pad_gpio_vtrip_sel   = c.vtrip_sel;
  assign pad_gpio_inenb       = c.inp_dis;
  assign pad_gpio_ib_mode_sel = c.ib_mode_sel;
  assign pad_gpio_ana_en      = c.ana_en;
  assign pad_gpio_ana_sel     = c.ana_sel;
  assign pad_gpio_ana_pol     = c.ana_pol;
  assign pad_gpio_dm          = c.dm;

  assign mgmt_gpio_in = pad_gpio_in;
  assign user_gpio_in = pad_gpio_in & pwr_ok;

  // With mgmt output disabled, pull-up/pull-down drive modes (dm=01x) need the
  // output driven to the opposite of dm[0] to select the pull direction.
  always_comb begin
    pad_gpio_outenb = user_gpio_oeb;
    pad_gpio_out    = user_gpio_out;
    if (c.mgmt_ena) begin
      pad_gpio_outenb = mgmt_gpio_oeb ? c.oeb : 1'b0;
      pad_gpio_out    = mgmt_gpio_out;
      if (mgmt_gpio_oeb && c.dm[2:1] == 2'b01)
        pad_gpio_out = ~c.dm[0];
    end
  end
endmodule

module gpio_control_bank #(
  parameter int NCH           = 2,
  parameter int PAD_CTRL_BITS = 13,
  parameter int STRICT_LOAD   = 1
) (
  input  logic                         serial_clock,
  input  logic                         reset,
  input  logic [NCH*PAD_CTRL_BITS-1:0] gpio_defaults,
  input  logic                         serial_shift,
  input  logic                         serial_data_in,
  input  logic                         serial_load,
  input  logic                         serial_capture,
  output logic                         serial_data_out,
  output logic                         cfg_loaded,
  output logic                         load_error,
  input  logic [NCH-1:0]               mgmt_gpio_out,
  input  logic [NCH-1:0]               mgmt_gpio_oeb,
  output logic [NCH-1:0]               mgmt_gpio_in,
  input  logic [NCH-1:0]               user_gpio_out,
  input  logic [NCH-1:0]               user_gpio_oeb,
  output logic [NCH-1:0]               user_gpio_in,
  input  logic                         user_power_good,
  output logic [NCH-1:0]               pad_gpio_holdover,
  output logic [NCH-1:0]               pad_gpio_slow_sel,
  output logic [NCH-1:0]               pad_gpio_vtrip_sel,
  output logic [NCH-1:0]               pad_gpio_inenb,
  output logic [NCH-1:0]               pad_gpio_ib_mode_sel,
  output logic [NCH-1:0]               pad_gpio_ana_en,
  output logic [NCH-1:0]               pad_gpio_ana_sel,
  output logic [NCH-1:0]               pad_gpio_ana_pol,
  output logic [NCH-1:0]               pad_gpio_outenb,
  output logic [NCH-1:0]               pad_gpio_out,
  output logic [3*NCH-1:0]             pad_gpio_dm,
  input  logic [NCH-1:0]               pad_gpio_in
);
  localparam int TOTAL = NCH * PAD_CTRL_BITS;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam logic [CW-1:0] TOTAL_C = CW'(TOTAL);

  logic [TOTAL-1:0] cfg_q, chain_q;
  logic [CW-1:0]    cnt_q;
  logic             sdo_q, loaded_q, err_q;
  logic [1:0]       pg_sync;
  logic             load_ok;

  assign load_ok = (STRICT_LOAD == 0) || (cnt_q == TOTAL_C);

  // Strobe priority is load > capture > shift; losers in the same cycle are dropped.
  always_ff @(posedge serial_clock) begin
    if (reset) begin
      cfg_q    <= gpio_defaults;
      chain_q  <= '0;
      cnt_q    <= '0;
      sdo_q    <= 1'b0;
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
      pg_sync  <= 2'b00;
    end else begin
      loaded_q <= 1'b0;
      pg_sync  <= {pg_sync[0], user_power_good};
      if (serial_load) begin
        cnt_q <= '0;
        if (load_ok) begin
          cfg_q    <= chain_q;
          loaded_q <= 1'b1;
          err_q    <= 1'b0;
        end else begin
          err_q <= 1'b1;
        end
      end else if (serial_capture) begin
        chain_q <= cfg_q;
        cnt_q   <= '0;
      end else if (serial_shift) begin
        chain_q <= {chain_q[TOTAL-2:0], serial_data_in};
        sdo_q   <= chain_q[TOTAL-1];
        if (cnt_q != TOTAL_C) cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign serial_data_out = sdo_q;
  assign cfg_loaded      = loaded_q;
  assign load_error      = err_q;

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    gpio_pad_lane u_lane (
      .cfg                  (cfg_q[k*PAD_CTRL_BITS +: 13]),
      .pwr_ok               (pg_sync[1]),
      .mgmt_gpio_out        (mgmt_gpio_out[k]),
      .mgmt_gpio_oeb        (mgmt_gpio_oeb[k]),
      .mgmt_gpio_in         (mgmt_gpio_in[k]),
      .user_gpio_out        (user_gpio_out[k]),
      .user_gpio_oeb        (user_gpio_oeb[k]),
      .user_gpio_in         (user_gpio_in[k]),
      .pad_gpio_holdover    (pad_gpio_holdover[k]),
      .pad_gpio_slow_sel    (pad_gpio_slow_sel[k]),
      .pad_gpio_vtrip_sel   (pad_gpio_vtrip_sel[k]),
      .pad_gpio_inenb       (pad_gpio_inenb[k]),
      .pad_gpio_ib_mode_sel (pad_gpio_ib_mode_sel[k]),
      .pad_gpio_ana_en      (pad_gpio_ana_en[k]),
      .pad_gpio_ana_sel     (pad_gpio_ana_sel[k]),
      .pad_gpio_ana_pol     (pad_gpio_ana_pol[k]),
      .pad_gpio_outenb      (pad_gpio_outenb[k]),
      .pad_gpio_out         (pad_gpio_out[k]),
      .pad_gpio_dm          (pad_gpio_dm[3*k +: 3]),
      .pad_gpio_in          (pad_gpio_in[k])
    );
  end
endmodule

// File: tb/tb_gpio_control_bank.sv
// Randomised + directed bench for gpio_control_bank against a queue-based reference model.

module tb_gpio_control_bank;
  localparam int NCH = 2, PB = 13, TOTAL = NCH * PB;

  logic serial_clock = 1'b0;
  always #5 serial_clock = ~serial_clock;

  logic reset, serial_shift, serial_data_in, serial_load, serial_capture, user_power_good;
  logic [TOTAL-1:0] gpio_defaults;
  logic serial_data_out, cfg_loaded, load_error;
  logic [NCH-1:0] mgmt_gpio_out, mgmt_gpio_oeb, mgmt_gpio_in, user_gpio_out, user_gpio_oeb, user_gpio_in;
  logic [NCH-1:0] pad_gpio_holdover, pad_gpio_slow_sel, pad_gpio_vtrip_sel, pad_gpio_inenb,
                  pad_gpio_ib_mode_sel, pad_gpio_ana_en, pad_gpio_ana_sel, pad_gpio_ana_pol,
                  pad_gpio_outenb, pad_gpio_out, pad_gpio_in;
  logic [3*NCH-1:0] pad_gpio_dm;

  gpio_control_bank #(.NCH(NCH), .PAD_CTRL_BITS(PB), .STRICT_LOAD(1)) dut (
    .serial_clock(serial_clock), .reset(reset), .gpio_defaults(gpio_defaults),
    .serial_shift(serial_shift), .serial_data_in(serial_data_in), .serial_load(serial_load),
    .serial_capture(serial_capture), .serial_data_out(serial_data_out), .cfg_loaded(cfg_loaded),
    .load_error(load_error), .mgmt_gpio_out(mgmt_gpio_out), .mgmt_gpio_oeb(mgmt_gpio_oeb),
    .mgmt_gpio_in(mgmt_gpio_in), .user_gpio_out(user_gpio_out), .user_gpio_oeb(user_gpio_oeb),
    .user_gpio_in(user_gpio_in), .user_power_good(user_power_good),
    .pad_gpio_holdover(pad_gpio_holdover), .pad_gpio_slow_sel(pad_gpio_slow_sel),
    .pad_gpio_vtrip_sel(pad_gpio_vtrip_sel), .pad_gpio_inenb(pad_gpio_inenb),
    .pad_gpio_ib_mode_sel(pad_gpio_ib_mode_sel), .pad_gpio_ana_en(pad_gpio_ana_en),
    .pad_gpio_ana_sel(pad_gpio_ana_sel), .pad_gpio_ana_pol(pad_gpio_ana_pol),
    .pad_gpio_outenb(pad_gpio_outenb), .pad_gpio_out(pad_gpio_out), .pad_gpio_dm(pad_gpio_dm),
    .pad_gpio_in(pad_gpio_in)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: chain held as a bit queue, front = oldest bit (next out).
  bit [TOTAL-1:0] m_cfg;
  bit m_chain[$];
  bit m_pg[$];
  int m_cnt;
  bit m_sdo, m_loaded, m_err, started = 1'b0;

  always @(posedge serial_clock) begin
    if (reset) begin
      m_cfg = gpio_defaults;
      m_chain = {};
      for (int i = 0; i < TOTAL; i++) m_chain.push_back(1'b0);
      m_cnt = 0; m_sdo = 0; m_loaded = 0; m_err = 0;
      m_pg = {};
      m_pg.push_back(1'b0); m_pg.push_back(1'b0);
      started = 1'b1;
    end else if (started) begin
      m_loaded = 0;
      m_pg.push_back(user_power_good);
      void'(m_pg.pop_front());
      if (serial_load) begin
        if (m_cnt == TOTAL) begin
          for (int i = 0; i < TOTAL; i++) m_cfg[i] = m_chain[TOTAL-1-i];
          m_loaded = 1; m_err = 0;
        end else m_err = 1;
        m_cnt = 0;
      end else if (serial_capture) begin
        for (int i = 0; i < TOTAL; i++) m_chain[TOTAL-1-i] = m_cfg[i];
        m_cnt = 0;
      end else if (serial_shift) begin
        m_sdo = m_chain.pop_front();
        m_chain.push_back(serial_data_in);
        if (m_cnt < TOTAL) m_cnt++;
      end
    end
  end

  always @(negedge serial_clock) begin
    if (started) begin
      logic [NCH-1:0] e_oe, e_out, e_uin;
      logic [8*NCH-1:0] e_st, a_st;
      logic [3*NCH-1:0] e_dm;
      for (int k = 0; k < NCH; k++) begin
        logic [PB-1:0] c;
        c = m_cfg[k*PB +: PB];
        e_dm[3*k +: 3] = c[12:10];
        e_st[8*k +: 8] = {c[2], c[8], c[9], c[3], c[4], c[5], c[6], c[7]};
        a_st[8*k +: 8] = {pad_gpio_holdover[k], pad_gpio_slow_sel[k], pad_gpio_vtrip_sel[k],
                          pad_gpio_inenb[k], pad_gpio_ib_mode_sel[k], pad_gpio_ana_en[k],
                          pad_gpio_ana_sel[k], pad_gpio_ana_pol[k]};
        if (!c[0]) begin
          e_oe[k] = user_gpio_oeb[k]; e_out[k] = user_gpio_out[k];
        end else if (!mgmt_gpio_oeb[k]) begin
          e_oe[k] = 1'b0; e_out[k] = mgmt_gpio_out[k];
        end else begin
          e_oe[k] = c[1];
          e_out[k] = (c[12:11] == 2'b01) ? ~c[10] : mgmt_gpio_out[k];
        end
        e_uin[k] = pad_gpio_in[k] & m_pg[0];
      end
      chk("pad_static", a_st, e_st);
      chk("pad_dm", pad_gpio_dm, e_dm);
      chk("pad_outenb", pad_gpio_outenb, e_oe);
      chk("pad_out", pad_gpio_out, e_out);
      chk("mgmt_in", mgmt_gpio_in, pad_gpio_in);
      chk("user_in", user_gpio_in, e_uin);
      chk("sdo", serial_data_out, m_sdo);
      chk("cfg_loaded", cfg_loaded, m_loaded);
      chk("load_error", load_error, m_err);
    end
  end

  task automatic tick();
    @(posedge serial_clock); #1;
  endtask

  task automatic shift_bits(input logic [TOTAL-1:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      serial_shift = 1'b1; serial_data_in = v[i]; tick();
    end
    serial_shift = 1'b0;
  endtask

  task automatic do_load();
    serial_load = 1'b1; tick(); serial_load = 1'b0;
  endtask

  initial begin
    logic [TOTAL-1:0] got;
    logic acc;
    reset = 1; serial_shift = 0; serial_data_in = 0; serial_load = 0; serial_capture = 0;
    user_power_good = 1; gpio_defaults = 26'h1803403;
    mgmt_gpio_out = 0; mgmt_gpio_oeb = 0; user_gpio_out = 0; user_gpio_oeb = 0; pad_gpio_in = 0;
    tick(); tick(); reset = 0;
    @(negedge serial_clock);
    chk("rst_dm", pad_gpio_dm, 6'h1D);
    chk("rst_sdo", serial_data_out, 0);
    chk("rst_err", load_error, 0);

    // Commit {ch1=0403, ch0=1802}: ch0 user-muxed, dm 110
    user_gpio_out = 2'b01;
    shift_bits(26'h0807802, TOTAL); do_load();
    @(negedge serial_clock);
    chk("load_pulse", cfg_loaded, 1);
    chk("load_dm", pad_gpio_dm, 6'h0E);
    chk("user_mux", pad_gpio_out, 2'b01);
    tick(); @(negedge serial_clock);
    chk("pulse_end", cfg_loaded, 0);

    // Short load rejected, full load accepted
    shift_bits('1, TOTAL - 1); do_load();
    @(negedge serial_clock);
    chk("short_err", load_error, 1);
    chk("short_nopulse", cfg_loaded, 0);
    chk("short_dm", pad_gpio_dm, 6'h0E);
    shift_bits(26'h1803403, TOTAL); do_load();
    @(negedge serial_clock);
    chk("full_err", load_error, 0);
    chk("full_dm", pad_gpio_dm, 6'h1D);

    // Readback stream and simultaneous-strobe priority
    serial_capture = 1; tick(); serial_capture = 0;
    for (int j = 1; j <= TOTAL; j++) begin
      serial_shift = 1; serial_data_in = 0; tick();
      got[TOTAL-j] = serial_data_out;
    end
    serial_shift = 0;
    chk("readback", got, 26'h1803403);
    serial_load = 1; serial_capture = 1; serial_shift = 1; serial_data_in = 1; tick();
    serial_load = 0; serial_capture = 0; serial_shift = 0;
    @(negedge serial_clock);
    chk("prio_dm", pad_gpio_dm, 6'h00);
    chk("prio_sdo", serial_data_out, 1);

    // Mgmt drive-mode override of pad_gpio_out
    mgmt_gpio_oeb = 2'b01; mgmt_gpio_out = 2'b00;
    shift_bits(26'h0000803, TOTAL); do_load();
    @(negedge serial_clock);
    chk("dm010_out", pad_gpio_out[0], 1);
    chk("dm010_oe", pad_gpio_outenb[0], 1);
    shift_bits(26'h0000C03, TOTAL); do_load();
    @(negedge serial_clock);
    chk("dm011_out", pad_gpio_out[0], 0);
    mgmt_gpio_oeb = 2'b00; mgmt_gpio_out = 2'b01; #1;
    chk("mgmt_out", pad_gpio_out[0], 1);
    chk("mgmt_oe", pad_gpio_outenb[0], 0);

    // Power gate latency
    pad_gpio_in = 2'b11; tick(); user_power_good = 0; tick();
    @(negedge serial_clock);
    chk("pg_lat1", user_gpio_in, 2'b11);
    tick(); @(negedge serial_clock);
    chk("pg_lat2", user_gpio_in, 2'b00);
    chk("pg_mgmt", mgmt_gpio_in, 2'b11);
    user_power_good = 1; tick(); tick();

    // Reset mid-shift discards chain and count
    shift_bits('1, 20); reset = 1; tick(); reset = 0;
    @(negedge serial_clock);
    chk("midrst_dm", pad_gpio_dm, 6'h1D);
    acc = 0;
    for (int j = 0; j < TOTAL - 1; j++) begin
      serial_shift = 1; serial_data_in = 1; tick(); acc |= serial_data_out;
    end
    serial_shift = 0;
    chk("midrst_chain0", acc, 0);
    do_load(); @(negedge serial_clock);
    chk("midrst_cnt", load_error, 1);

    // Randomised phase, checked every cycle against the model
    for (int it = 0; it < 150; it++) begin
      int n;
      bit full;
      full = ($urandom_range(0, 1) == 1);
      n = full ? TOTAL : $urandom_range(20, 30);
      for (int j = 0; j < n; j++) begin
        serial_shift = full ? 1'b1 : ($urandom_range(0, 3) != 0);
        serial_data_in = $urandom_range(0, 1);
        mgmt_gpio_out = $urandom; mgmt_gpio_oeb = $urandom;
        user_gpio_out = $urandom; user_gpio_oeb = $urandom; pad_gpio_in = $urandom;
        if ($urandom_range(0, 15) == 0) user_power_good = ~user_power_good;
        tick();
      end
      serial_shift = 0;
      serial_load = ($urandom_range(0, 2) != 0);
      serial_capture = ($urandom_range(0, 3) == 0);
      serial_shift = ($urandom_range(0, 1) == 1);
      tick();
      serial_load = 0; serial_capture = 0; serial_shift = 0;
      if ($urandom_range(0, 30) == 0) begin
        gpio_defaults = {$urandom, $urandom};
        reset = 1; tick(); reset = 0;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
